// File: rtl/fifo_seg_display_if.sv
// FIFO-read handshake and 4-digit 7-segment display signals for fifo_seg_display.
// master: the display block (pops the FIFO, drives the display).
// slave:  the FIFO / board side.
interface fifo_seg_display_if;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       rd_en;
  logic [7:0] seg;
  logic [3:0] an;
  logic       busy;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output rd_en,
    output seg,
    output an,
    output busy
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  rd_en,
    input  seg,
    input  an,
    input  busy
  );
endinterface

// File: rtl/fifo_seg_display.sv
// fifo_seg_display: pops one byte at a time from a FIFO, holds it for DWELL cycles and shows
// it on a multiplexed 4-digit 7-segment display together with an 8-bit pop counter:
//   digit 1:0 = last popped byte, digit 3:2 = pop count (hex).
// Optional feature: define FIFO_SEG_DP_FLAG_EN to light the digit-0 decimal point while the
// FIFO is empty after at least one byte has been shown (drained indicator).
module fifo_seg_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DWELL       = 100000000
) (
  input logic                clk,
  input logic                rst_n,
  fifo_seg_display_if.master bus
);

  localparam int unsigned ScanW  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DwellW = (DWELL > 2) ? $clog2(DWELL) : 1;

  localparam logic [ScanW-1:0]  ScanMax   = ScanW'(REFRESH_DIV - 1);
  localparam logic [DwellW-1:0] DwellLoad = DwellW'(DWELL - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPop   = 2'd1;
  localparam logic [1:0] StLatch = 2'd2;
  localparam logic [1:0] StShow  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [7:0]        disp_byte_q, disp_byte_d;
  logic [7:0]        pop_count_q, pop_count_d;
  logic              shown_q, shown_d;

  logic [ScanW-1:0]  scan_q, scan_d;
  logic [1:0]        digit_q, digit_d;

  logic [7:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;
  logic [3:0]        nibble;
  logic [7:0]        hex_code;
  logic              dp;

  // Pop sequencer: IDLE samples fifo_empty, POP strobes rd_en, LATCH captures, SHOW dwells.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    disp_byte_d = disp_byte_q;
    pop_count_d = pop_count_q;
    shown_d     = shown_q;
    case (state_q)
      StIdle: begin
        if (!bus.fifo_empty) state_d = StPop;
      end
      StPop: begin
        state_d = StLatch;
      end
      StLatch: begin
        disp_byte_d = bus.fifo_data;
        pop_count_d = pop_count_q + 8'd1;
        shown_d     = 1'b1;
        dwell_d     = DwellLoad;
        state_d     = StShow;
      end
      StShow: begin
        if (dwell_q != '0) dwell_d = dwell_q - DwellW'(1);
        // Leave as the counter reaches zero so pops are DWELL+2 cycles apart.
        if (dwell_q <= DwellW'(1)) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dwell_q     <= '0;
      disp_byte_q <= 8'h00;
      pop_count_q <= 8'h00;
      shown_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      disp_byte_q <= disp_byte_d;
      pop_count_q <= pop_count_d;
      shown_q     <= shown_d;
    end
  end

  // Free-running digit scan, independent of the sequencer.
  always_comb begin
    scan_d  = scan_q + ScanW'(1);
    digit_d = digit_q;
    if (scan_q == ScanMax) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // Scan counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q  <= '0;
      digit_q <= 2'd0;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
    end
  end

  // Nibble select, hex decode and decimal point for the currently scanned digit.
  always_comb begin
    nibble = disp_byte_q[3:0];
    case (digit_q)
      2'd0:    nibble = disp_byte_q[3:0];
      2'd1:    nibble = disp_byte_q[7:4];
      2'd2:    nibble = pop_count_q[3:0];
      default: nibble = pop_count_q[7:4];
    endcase

    hex_code = 8'hFF;
    case (nibble)
      4'h0:    hex_code = 8'hC0;
      4'h1:    hex_code = 8'hF9;
      4'h2:    hex_code = 8'hA4;
      4'h3:    hex_code = 8'hB0;
      4'h4:    hex_code = 8'h99;
      4'h5:    hex_code = 8'h92;
      4'h6:    hex_code = 8'h82;
      4'h7:    hex_code = 8'hF8;
      4'h8:    hex_code = 8'h80;
      4'h9:    hex_code = 8'h90;
      4'hA:    hex_code = 8'h88;
      4'hB:    hex_code = 8'h83;
      4'hC:    hex_code = 8'hC6;
      4'hD:    hex_code = 8'hA1;
      4'hE:    hex_code = 8'h86;
      default: hex_code = 8'h8E;
    endcase

`ifdef FIFO_SEG_DP_FLAG_EN
    dp = ~((digit_q == 2'd0) && bus.fifo_empty && shown_q);
`else
    dp = 1'b1;
`endif

    // Blank until the first byte has been latched; the scan keeps running regardless.
    seg_d = shown_q ? {dp, hex_code[6:0]} : 8'hFF;
    an_d  = ~(4'b0001 << digit_q);
  end

  // Registered display drive, one cycle behind the digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 8'hFF;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.rd_en = (state_q == StPop);
  assign bus.busy  = (state_q != StIdle);
  assign bus.seg   = seg_q;
  assign bus.an    = an_q;

endmodule
